// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide engine:
// operation encodings, controller states and the default operand width.
package hilo_muldiv_unit_pkg;

    localparam int unsigned XLEN = 32;

    // Matches Function_opcode[1:0] of mult/multu/div/divu (0x18..0x1B)
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative unsigned datapath: one add-shift multiply step or one
// restoring subtract-shift divide step per enabled cycle. Works purely
// on magnitudes; sign handling lives in the controller.
module muldiv_iter_core #(
    parameter int unsigned W = 32
) (
    input  logic           clock,
    input  logic           load,
    input  logic           step,
    input  logic           is_div,
    input  logic [W-1:0]   op_a,
    input  logic [W-1:0]   op_b,
    output logic [2*W-1:0] product,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder
);

    logic [2*W-1:0] acc;
    logic [W-1:0]   mcand;
    logic [W-1:0]   divisor;
    logic [W-1:0]   rem;
    logic [W-1:0]   quot;
    logic           div_mode;

    logic [W:0]     add_sum;
    logic [2*W-1:0] acc_next;
    logic [W:0]     rem_shift;
    logic [W-1:0]   rem_next;
    logic [W-1:0]   quot_next;

    // Next-step values for both algorithms
    always_comb begin
        add_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, mcand};
        acc_next  = {1'b0, acc[2*W-1:1]};
        if (acc[0]) begin
            acc_next = {add_sum, acc[W-1:1]};
        end
        rem_shift = {rem, quot[W-1]};
        rem_next  = rem_shift[W-1:0];
        quot_next = {quot[W-2:0], 1'b0};
        if (rem_shift >= {1'b0, divisor}) begin
            // Remainder after subtraction is below the divisor, so W bits suffice
            rem_next  = rem_shift[W-1:0] - divisor;
            quot_next = {quot[W-2:0], 1'b1};
        end
    end

    // Operand load on launch, otherwise one iteration per step cycle
    always_ff @(posedge clock) begin
        if (load) begin
            acc      <= {{W{1'b0}}, op_b};
            mcand    <= op_a;
            divisor  <= op_b;
            rem      <= '0;
            quot     <= op_a;
            div_mode <= is_div;
        end else if (step) begin
            if (div_mode) begin
                rem  <= rem_next;
                quot <= quot_next;
            end else begin
                acc <= acc_next;
            end
        end
    end

    assign product   = acc;
    assign quotient  = quot;
    assign remainder = rem;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO
// registers. Controller FSM (IDLE -> CALC x XLEN -> FIX), sign handling,
// divide-by-zero policy and the mthi/mtlo/mfhi/mflo moves live here.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int unsigned     XLEN    = hilo_muldiv_unit_pkg::XLEN,
    parameter logic [XLEN-1:0] DIV0_LO = {XLEN{1'b1}}
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            Start,
    input  logic [1:0]      Op,
    input  logic [XLEN-1:0] Read_data_1,
    input  logic [XLEN-1:0] Read_data_2,
    input  logic            Mthi,
    input  logic            Mtlo,
    input  logic            Mfhi,
    input  logic            Mflo,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] HI_result,
    output logic [XLEN-1:0] LO_result,
    output logic [XLEN-1:0] Hilo_rdata
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    state_e            state;
    logic [CNT_W-1:0]  count;
    logic              div_op;
    logic              neg_main;
    logic              neg_rem;
    logic              div_zero;
    logic [XLEN-1:0]   dividend_raw;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic              done;

    op_e               op_in;
    logic              signed_op;
    logic              start_ok;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;

    logic [2*XLEN-1:0] prod_mag;
    logic [XLEN-1:0]   quot_mag;
    logic [XLEN-1:0]   rem_mag;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;

    // Two's-complement magnitude; the most negative value maps to 2^(XLEN-1) unsigned
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

    assign op_in     = op_e'(Op);
    assign signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign start_ok  = (state == IDLE) && Start;
    assign mag_a     = magnitude(Read_data_1, signed_op);
    assign mag_b     = magnitude(Read_data_2, signed_op);

    muldiv_iter_core #(
        .W(XLEN)
    ) u_core (
        .clock     (clock),
        .load      (start_ok),
        .step      (state == CALC),
        .is_div    (op_in == OP_DIV || op_in == OP_DIVU),
        .op_a      (mag_a),
        .op_b      (mag_b),
        .product   (prod_mag),
        .quotient  (quot_mag),
        .remainder (rem_mag)
    );

    // Re-apply result signs to the unsigned magnitudes
    always_comb begin
        prod_fix = neg_main ? (~prod_mag + 1'b1) : prod_mag;
        quot_fix = neg_main ? (~quot_mag + 1'b1) : quot_mag;
        rem_fix  = neg_rem  ? (~rem_mag + 1'b1)  : rem_mag;
    end

    // Controller FSM with HI/LO ownership and registered Done pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            div_op       <= 1'b0;
            neg_main     <= 1'b0;
            neg_rem      <= 1'b0;
            div_zero     <= 1'b0;
            dividend_raw <= '0;
            hi           <= '0;
            lo           <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        // Start has priority over register moves in the same cycle
                        div_op       <= (op_in == OP_DIV) || (op_in == OP_DIVU);
                        neg_main     <= signed_op && (Read_data_1[XLEN-1] ^ Read_data_2[XLEN-1]);
                        neg_rem      <= signed_op && Read_data_1[XLEN-1];
                        div_zero     <= (Read_data_2 == '0);
                        dividend_raw <= Read_data_1;
                        count        <= '0;
                        state        <= CALC;
                    end else begin
                        if (Mthi) begin
                            hi <= Read_data_1;
                        end
                        if (Mtlo) begin
                            lo <= Read_data_1;
                        end
                    end
                end
                CALC: begin
                    if (count == CNT_W'(XLEN - 1)) begin
                        count <= '0;
                        state <= FIX;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    if (div_op) begin
                        if (div_zero) begin
                            hi <= dividend_raw;
                            lo <= DIV0_LO;
                        end else begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end
                    end else begin
                        hi <= prod_fix[2*XLEN-1:XLEN];
                        lo <= prod_fix[XLEN-1:0];
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Busy       = (state != IDLE);
    assign Done       = done;
    assign HI_result  = hi;
    assign LO_result  = lo;
    assign Hilo_rdata = Mfhi ? hi : (Mflo ? lo : '0);

endmodule
